// File: rtl/tx_cic_interp.sv
// Transmit-path I/Q CIC interpolator (3 stages, zero-stuff by RATE) with a run/drain FSM.
// Optional macro TX_CIC_HOLD_EN: an underflow slot repeats the last accepted sample instead of zero.
module tx_cic_interp #(
  parameter int unsigned RATE  = 8,
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_i,
  input  logic [IN_W-1:0]  in_q,
  output logic [OUT_W-1:0] out_i,
  output logic [OUT_W-1:0] out_q,
  output logic             active,
  output logic             underflow
);

  localparam int unsigned L         = $clog2(RATE);
  localparam int unsigned CW        = IN_W + 3;
  localparam int unsigned W         = IN_W + 3 * L;
  localparam int unsigned S         = 2 * L - (OUT_W - IN_W);
  localparam int unsigned DRAIN_LEN = 4 * RATE + 4;
  localparam int unsigned DW        = $clog2(DRAIN_LEN);
  localparam int unsigned HSH       = (S > 0) ? S - 1 : 0;

  localparam logic [L-1:0]          LAST  = L'(RATE - 1);
  localparam logic [DW-1:0]         DLAST = DW'(DRAIN_LEN - 1);
  localparam logic signed [W:0]     HALF  = (S > 0) ? ((W+1)'(1) << HSH) : '0;
  localparam logic signed [W:0]     OMAX  = (W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [W:0]     OMIN  = ~OMAX;

`ifdef TX_CIC_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [L-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            underflow_q, underflow_d;
  logic            active_q;
  logic            slot_c, take_c, uflow_c, clr_c;

  // Phase/drain control; slot_c marks the low-rate update edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + L'(1);
    dcnt_d      = dcnt_q;
    underflow_d = underflow_q;
    slot_c      = 1'b0;
    take_c      = 1'b0;
    uflow_c     = 1'b0;
    clr_c       = 1'b0;
    unique case (state_q)
      IDLE: begin
        clr_c = 1'b1;
        cnt_d = '0;
        if (run) begin
          state_d     = RUN;
          underflow_d = 1'b0;
        end
      end
      RUN: begin
        slot_c = (cnt_q == LAST);
        if (!run) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end else if (slot_c) begin
          if (in_valid) begin
            take_c = 1'b1;
          end else begin
            uflow_c     = 1'b1;
            underflow_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        slot_c = (cnt_q == LAST);
        dcnt_d = dcnt_q + DW'(1);
        if (dcnt_q == DLAST) begin
          state_d = IDLE;
          clr_c   = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        clr_c   = 1'b1;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dcnt_q      <= '0;
      underflow_q <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dcnt_q      <= dcnt_d;
      underflow_q <= underflow_d;
      active_q    <= (state_d != IDLE);
    end
  end

  // The slot is refused combinationally the moment run drops.
  assign in_ready  = (state_q == RUN) && run && (cnt_q == LAST);
  assign active    = active_q;
  assign underflow = underflow_q;

  // Round half up, then clamp; only the rounding increment can exceed the range.
  function automatic logic [OUT_W-1:0] scale(input logic [W-1:0] acc);
    logic signed [W:0] t;
    logic [OUT_W-1:0]  r;
    t = ($signed({acc[W-1], acc}) + HALF) >>> S;
    if (t > OMAX) begin
      r = OMAX[OUT_W-1:0];
    end else if (t < OMIN) begin
      r = OMIN[OUT_W-1:0];
    end else begin
      r = t[OUT_W-1:0];
    end
    return r;
  endfunction

  logic [IN_W-1:0]  din      [2];
  logic [CW-1:0]    samp_c   [2];
  logic [CW-1:0]    c1_c     [2];
  logic [CW-1:0]    c2_c     [2];
  logic [CW-1:0]    d1_q     [2];
  logic [CW-1:0]    d1_d     [2];
  logic [CW-1:0]    d2_q     [2];
  logic [CW-1:0]    d2_d     [2];
  logic [CW-1:0]    d3_q     [2];
  logic [CW-1:0]    d3_d     [2];
  logic [CW-1:0]    comb_q   [2];
  logic [CW-1:0]    comb_d   [2];
  logic [IN_W-1:0]  hold_q   [2];
  logic [IN_W-1:0]  hold_d   [2];
  logic [W-1:0]     int1_q   [2];
  logic [W-1:0]     int1_d   [2];
  logic [W-1:0]     int2_q   [2];
  logic [W-1:0]     int2_d   [2];
  logic [W-1:0]     int3_q   [2];
  logic [W-1:0]     int3_d   [2];
  logic [OUT_W-1:0] dout_q   [2];
  logic [OUT_W-1:0] dout_d   [2];

  assign din[0] = in_i;
  assign din[1] = in_q;

  // Channel 0 is I, channel 1 is Q; both share the same control so they stay aligned.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      d1_d[c]   = d1_q[c];
      d2_d[c]   = d2_q[c];
      d3_d[c]   = d3_q[c];
      comb_d[c] = comb_q[c];
      hold_d[c] = hold_q[c];
      samp_c[c] = '0;
      if (take_c) begin
        samp_c[c] = CW'($signed(din[c]));
      end else if (uflow_c && HOLD_EN) begin
        samp_c[c] = CW'($signed(hold_q[c]));
      end
      c1_c[c] = samp_c[c] - d1_q[c];
      c2_c[c] = c1_c[c] - d2_q[c];
      if (slot_c) begin
        d1_d[c]   = samp_c[c];
        d2_d[c]   = c1_c[c];
        d3_d[c]   = c2_c[c];
        comb_d[c] = c2_c[c] - d3_q[c];
      end
      if (take_c) begin
        hold_d[c] = din[c];
      end
      // Zero-stuffing: the comb result enters only on the first high-rate phase.
      int1_d[c] = int1_q[c] + ((cnt_q == '0) ? W'($signed(comb_q[c])) : '0);
      int2_d[c] = int2_q[c] + int1_q[c];
      int3_d[c] = int3_q[c] + int2_q[c];
      dout_d[c] = scale(int3_q[c]);
      if (clr_c) begin
        d1_d[c]   = '0;
        d2_d[c]   = '0;
        d3_d[c]   = '0;
        comb_d[c] = '0;
        hold_d[c] = '0;
        int1_d[c] = '0;
        int2_d[c] = '0;
        int3_d[c] = '0;
        dout_d[c] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < 2; c++) begin
        d1_q[c]   <= '0;
        d2_q[c]   <= '0;
        d3_q[c]   <= '0;
        comb_q[c] <= '0;
        hold_q[c] <= '0;
        int1_q[c] <= '0;
        int2_q[c] <= '0;
        int3_q[c] <= '0;
        dout_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        d1_q[c]   <= d1_d[c];
        d2_q[c]   <= d2_d[c];
        d3_q[c]   <= d3_d[c];
        comb_q[c] <= comb_d[c];
        hold_q[c] <= hold_d[c];
        int1_q[c] <= int1_d[c];
        int2_q[c] <= int2_d[c];
        int3_q[c] <= int3_d[c];
        dout_q[c] <= dout_d[c];
      end
    end
  end

  assign out_i = dout_q[0];
  assign out_q = dout_q[1];

endmodule

// File: tb/tb_tx_cic_interp.sv
// Randomised bench for tx_cic_interp: reference output is the zero-stuffed sample stream
// convolved with the triple-boxcar CIC impulse response, then rounded and clamped.
module tb_tx_cic_interp;

  localparam int RATE      = 8;
  localparam int IN_W      = 16;
  localparam int OUT_W     = 18;
  localparam int L         = 3;
  localparam int S         = 2 * L - (OUT_W - IN_W);
  localparam int HLEN      = 3 * RATE - 2;
  localparam int DRAIN_CYC = 4 * RATE + 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             run;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_i;
  logic [IN_W-1:0]  in_q;
  logic [OUT_W-1:0] out_i;
  logic [OUT_W-1:0] out_q;
  logic             active;
  logic             underflow;

  always #5 clk = ~clk;

  tx_cic_interp #(.RATE(RATE), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .in_valid(in_valid), .in_ready(in_ready),
    .in_i(in_i), .in_q(in_q), .out_i(out_i), .out_q(out_q),
    .active(active), .underflow(underflow)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference state: mode 0 idle, 1 run, 2 drain.
  longint h [HLEN];
  int     m_mode, m_phase, m_dcnt, m_edge;
  bit     m_uf;
  int     m_last_i, m_last_q;
  int     ev_edge[$];
  int     ev_i[$];
  int     ev_q[$];
  bit     obs_rdy;

  function automatic longint scale(input longint y);
    longint t;
    t = (y + (longint'(1) <<< (S - 1))) >>> S;
    if (t > 131071) t = 131071;
    if (t < -131072) t = -131072;
    return t;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_dcnt = 0; m_uf = 0;
    m_last_i = 0; m_last_q = 0;
    ev_edge.delete(); ev_i.delete(); ev_q.delete();
  endtask

  task automatic model_out(output longint ei, output longint eq);
    longint yi, yq;
    int k;
    yi = 0; yq = 0;
    foreach (ev_edge[j]) begin
      k = m_edge - 4 - ev_edge[j];
      if (k >= 0 && k < HLEN) begin
        yi += h[k] * ev_i[j];
        yq += h[k] * ev_q[j];
      end
    end
    ei = scale(yi);
    eq = scale(yq);
  endtask

  task automatic model_edge(input bit r, input bit v, input int xi, input int xq);
    m_edge++;
    case (m_mode)
      0: if (r) begin m_mode = 1; m_phase = 0; m_uf = 0; end
      1: begin
        if (!r) begin
          m_mode = 2; m_dcnt = 0;
        end else if (m_phase == RATE - 1) begin
          if (v) begin
            ev_edge.push_back(m_edge); ev_i.push_back(xi); ev_q.push_back(xq);
            m_last_i = xi; m_last_q = xq;
          end else begin
            m_uf = 1;
`ifdef TX_CIC_HOLD_EN
            ev_edge.push_back(m_edge); ev_i.push_back(m_last_i); ev_q.push_back(m_last_q);
`endif
          end
        end
        m_phase = (m_phase + 1) % RATE;
      end
      default: begin
        m_dcnt++;
        m_phase = (m_phase + 1) % RATE;
        if (m_dcnt == DRAIN_CYC) begin
          m_mode = 0;
          m_last_i = 0; m_last_q = 0;
          ev_edge.delete(); ev_i.delete(); ev_q.delete();
        end
      end
    endcase
    while (ev_edge.size() > 0 && ev_edge[0] < m_edge - 4 - HLEN) begin
      void'(ev_edge.pop_front()); void'(ev_i.pop_front()); void'(ev_q.pop_front());
    end
  endtask

  // One high-rate cycle: check registered outputs, drive inputs, check ready, clock the model.
  task automatic step(input bit r, input bit v, input int xi, input int xq);
    longint ei, eq;
    bit exp_rdy;
    @(negedge clk);
    model_out(ei, eq);
    check_eq("out_i", longint'($signed(out_i)), ei);
    check_eq("out_q", longint'($signed(out_q)), eq);
    check_eq("active", longint'(active), longint'(m_mode != 0));
    check_eq("underflow", longint'(underflow), longint'(m_uf));
    run = r; in_valid = v; in_i = 16'(xi); in_q = 16'(xq);
    #1;
    exp_rdy = (m_mode == 1) && r && (m_phase == RATE - 1);
    obs_rdy = in_ready;
    check_eq("in_ready", longint'(in_ready), longint'(exp_rdy));
    @(posedge clk);
    model_edge(r, v, xi, xq);
    #1;
  endtask

  function automatic int rnd();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  bit     go, sent, dropped;
  int     imp_e, fell;
  longint imp_sum;

  initial begin
    for (int k = 0; k < HLEN; k++) h[k] = 0;
    for (int a = 0; a < RATE; a++)
      for (int b = 0; b < RATE; b++)
        for (int c = 0; c < RATE; c++)
          h[a + b + c] += 1;
    m_edge = 0;
    model_reset();

    rst = 1'b0; run = 1'b0; in_valid = 1'b0; in_i = '0; in_q = '0;
    #3;
    check_eq("rst_out_i", longint'($signed(out_i)), 0);
    check_eq("rst_out_q", longint'($signed(out_q)), 0);
    check_eq("rst_active", longint'(active), 0);
    check_eq("rst_ready", longint'(in_ready), 0);
    check_eq("rst_uf", longint'(underflow), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    repeat (3) step(1'b0, 1'b0, 0, 0);

    // DC
    repeat (48) step(1'b1, 1'b1, 1000, -1000);
    check_eq("dc_i", longint'($signed(out_i)), 4000);
    check_eq("dc_q", longint'($signed(out_q)), -4000);
    check_eq("dc_uf", longint'(underflow), 0);

    // Impulse
    repeat (40) step(1'b1, 1'b1, 0, 0);
    sent = 0; imp_e = -1; imp_sum = 0;
    for (int k = 0; k < 64; k++) begin
      go = !sent && (m_mode == 1) && (m_phase == RATE - 1);
      step(1'b1, 1'b1, go ? 16384 : 0, 0);
      if (go) begin sent = 1; imp_e = m_edge; end
      if (imp_e >= 0) imp_sum += longint'($signed(out_i));
      if (imp_e >= 0 && m_edge == imp_e + 4)
        check_eq("imp_peak", longint'($signed(out_i)), 1024);
    end
    check_eq("imp_sum", imp_sum, 524288);
    check_eq("imp_tail", longint'($signed(out_i)), 0);

    // Full-scale step in both directions
    repeat (48) step(1'b1, 1'b1, -32768, 32767);
    check_eq("fs_neg_i", longint'($signed(out_i)), -131072);
    check_eq("fs_pos_q", longint'($signed(out_q)), 131068);
    repeat (48) step(1'b1, 1'b1, 32767, -32768);
    check_eq("fs_pos_i", longint'($signed(out_i)), 131068);
    check_eq("fs_neg_q", longint'($signed(out_q)), -131072);

    repeat (240) step(1'b1, 1'b1, rnd(), rnd());

    // Underflow: one missing sample on a DC stream
    repeat (40) step(1'b1, 1'b1, 1000, -1000);
    dropped = 0;
    for (int k = 0; k < 48; k++) begin
      go = !dropped && (k >= 8) && (m_phase == RATE - 1);
      if (go) dropped = 1;
      step(1'b1, !go, 1000, -1000);
    end
    check_eq("uf_set", longint'(underflow), 1);
    check_eq("uf_recover_i", longint'($signed(out_i)), 4000);
    repeat (160) step(1'b1, $urandom_range(9) != 0, rnd(), rnd());

    // Drain, dropping run exactly on a slot cycle
    for (int k = 0; k < RATE && m_phase != RATE - 1; k++) step(1'b1, 1'b1, rnd(), rnd());
    step(1'b0, 1'b1, rnd(), rnd());
    check_eq("drain_rdy", longint'(obs_rdy), 0);
    fell = -1;
    for (int k = 1; k <= 60; k++) begin
      step(1'($urandom_range(1)), 1'b1, rnd(), rnd());
      if (active == 1'b0) begin fell = k; break; end
    end
    check_eq("drain_len", fell, DRAIN_CYC);
    check_eq("drain_out_i", longint'($signed(out_i)), 0);
    check_eq("drain_out_q", longint'($signed(out_q)), 0);
    repeat (2) step(1'b0, 1'b0, 0, 0);
    check_eq("uf_sticky", longint'(underflow), 1);

    step(1'b1, 1'b1, 0, 0);
    check_eq("uf_clr", longint'(underflow), 0);
    repeat (40) step(1'b1, 1'b1, 1000, -1000);

    // Asynchronous reset between clock edges
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_out_i", longint'($signed(out_i)), 0);
    check_eq("arst_out_q", longint'($signed(out_q)), 0);
    check_eq("arst_active", longint'(active), 0);
    check_eq("arst_ready", longint'(in_ready), 0);
    check_eq("arst_uf", longint'(underflow), 0);
    run = 1'b0; in_valid = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    repeat (4) step(1'b0, 1'b1, rnd(), rnd());
    check_eq("post_rst_idle", longint'(active), 0);
    repeat (120) step(1'b1, $urandom_range(7) != 0, rnd(), rnd());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
